// File: rtl/div16_seq_pkg.sv
// Shared definitions for the sequential restoring divider (div16_seq).
// Holds the FSM state encoding, the divide-by-zero quotient constant and
// the helper that sizes the iteration counter.

package div16_seq_pkg;

    // FSM state encoding, kept as plain constants for legacy tools
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Quotient reported on divide-by-zero; sliced to WIDTH at the use site
    localparam logic [63:0] DIV_ZERO_QUOT = '1;

    // Counter must hold the values 0..width
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sub16_cmp.sv
// WIDTH+1-bit subtractor used by the divider's restore decision.
// borrow=0 means a >= b, so the difference replaces the partial remainder.

module sub16_cmp #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    // One extra bit on the left captures the borrow out of the subtraction
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div16_seq.sv
// Iterative restoring divider: one quotient bit per clock with a
// start/busy/done handshake and V/N/Z flags matching the adder flags.
// Optional build macro: DIV_SIGNED_EN adds the sgn port and truncating
// signed division (operands folded to magnitudes, signs reapplied at FIN).

module div16_seq
    import div16_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             V,
    output logic             N,
    output logic             Z
);

    localparam int unsigned      CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    // Partial remainder after restore is always below the divisor, so WIDTH
    // bits hold it; the shifted WIDTH+1-bit value only exists combinationally.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvs_q;
    logic             dz_q;

    logic             done_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             v_q, n_q, z_q;

    logic             accept;
    logic             div_zero;
    logic [WIDTH-1:0] dvd_eff, dvs_eff;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] r_next, q_next;
    logic             unused_diff_msb;

    logic [WIDTH-1:0] res_quot, res_rem;
    logic             res_v;

    assign accept   = (state_q == ST_IDLE) && start;
    assign div_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
    logic neg_q, rneg_q, ovf_q;
    logic is_min, is_m1;

    // Fold signed operands to magnitudes; MIN maps onto itself as unsigned
    always_comb begin
        dvd_eff = dividend;
        dvs_eff = divisor;
        if (sgn && dividend[WIDTH-1]) dvd_eff = ~dividend + WIDTH'(1);
        if (sgn && divisor[WIDTH-1])  dvs_eff = ~divisor + WIDTH'(1);
    end

    assign is_min = (dividend == {1'b1, {(WIDTH-1){1'b0}}});
    assign is_m1  = (divisor == '1);

    // Capture sign handling decisions at accept so sgn may change mid-run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            neg_q  <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q <= sgn && dividend[WIDTH-1];
            ovf_q  <= sgn && is_min && is_m1;
        end
    end
`else
    assign dvd_eff = dividend;
    assign dvs_eff = divisor;
`endif

    // Next-state logic: zero divisor skips straight to FIN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = div_zero ? ST_FIN : ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == LAST) state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // One restoring step: shift in the next dividend bit, trial subtract
    assign r_shift = {r_q, q_q[WIDTH-1]};

    sub16_cmp #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a      (r_shift),
        .b      ({1'b0, dvs_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    // A successful subtract leaves a result below the divisor, so the top bit is zero
    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        r_next = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next = {q_q[WIDTH-2:0], ~borrow};
    end

    // Working registers: load on accept, iterate in RUN, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            r_q   <= '0;
            q_q   <= '0;
            dvs_q <= '0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            r_q   <= '0;
            // On divide-by-zero the raw dividend is kept to become the remainder
            q_q   <= div_zero ? dividend : dvd_eff;
            dvs_q <= dvs_eff;
            dz_q  <= div_zero;
        end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q + CNT_W'(1);
            r_q   <= r_next;
            q_q   <= q_next;
        end
    end

    // Final result selection applied on the FIN edge
    always_comb begin
        res_quot = q_q;
        res_rem  = r_q;
        res_v    = 1'b0;
        if (dz_q) begin
            res_quot = DIV_ZERO_QUOT[WIDTH-1:0];
            res_rem  = q_q;
            res_v    = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            if (neg_q)  res_quot = ~q_q + WIDTH'(1);
            if (rneg_q) res_rem  = ~r_q + WIDTH'(1);
            res_v = ovf_q;
`endif
        end
    end

    // Output registers: only the FIN edge or reset may change them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            v_q    <= 1'b0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
        end else begin
            done_q <= (state_q == ST_FIN);
            if (state_q == ST_FIN) begin
                quot_q <= res_quot;
                rem_q  <= res_rem;
                v_q    <= res_v;
                n_q    <= res_quot[WIDTH-1];
                z_q    <= (res_quot == '0);
            end
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;
    assign V    = v_q;
    assign N    = n_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed cases plus randomized operands
// compared against an arithmetic reference model (/ and %).

module tb_div16_seq;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
`ifdef DIV_SIGNED_EN
    logic          sgn;
`endif
    logic          busy;
    logic          done;
    logic [W-1:0]  quot;
    logic [W-1:0]  rem;
    logic          V, N, Z;

    int n_checks = 0;
    int n_fail   = 0;

    // Last completed result, which outputs must hold while busy
    logic [W-1:0] held_q = '0;

    div16_seq #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
`ifdef DIV_SIGNED_EN
        .sgn      (sgn),
`endif
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .V        (V),
        .N        (N),
        .Z        (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, divide-by-zero and MIN/-1 rules
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic v);
        int sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
            v = 1'b1;
        end else if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            v  = (a == 16'h8000) && (b == 16'hFFFF);
        end else begin
            q = a / b;
            r = a % b;
            v = 1'b0;
        end
    endfunction

    // Issue one division (caller is #1 after an edge, DUT idle or in its done
    // cycle) and check latency, hold behaviour and results. poke>0 pulses a
    // stray start with other operands that many cycles after accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input int poke);
        logic [W-1:0] eq, er;
        logic         ev;
        int           lat, k;
        model(a, b, s, eq, er, ev);
        lat = (b == 0) ? 1 : W + 1;
        dividend = a;
        divisor  = b;
`ifdef DIV_SIGNED_EN
        sgn = s;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = i;
                break;
            end
            check("busy_during_run", busy, 1'b1);
            check("quot_held", quot, held_q);
            if (i == poke) begin
                start    = 1'b1;
                dividend = 16'h1234;
                divisor  = 16'h0001;
            end
            if (i == poke + 1) start = 1'b0;
        end
        check("latency", k, lat);
        check("busy_in_done", busy, 1'b0);
        check("quot", quot, eq);
        check("rem", rem, er);
        check("V", V, ev);
        check("N", N, eq[W-1]);
        check("Z", Z, eq == 0);
        held_q = eq;
    endtask

    // One idle edge after a done cycle: pulse must have dropped
    task automatic idle_after_done();
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int seen;
        logic [W-1:0] a, b;
        bit s;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_SIGNED_EN
        sgn      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_quot", quot, 16'h0);
        check("rst_rem", rem, 16'h0);
        check("rst_flags", {V, N, Z}, 3'b000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(16'd100, 16'd7, 1'b0, 0);
        idle_after_done();
        run_op(16'd5, 16'd0, 1'b0, 0);
        idle_after_done();
        run_op(16'd3, 16'hFFFF, 1'b0, 3);
        // Start held into the done cycle: back-to-back accept
        run_op(16'hFFFF, 16'd1, 1'b0, 0);
        idle_after_done();

        // Reset mid-run: abort, clear outputs, no done afterwards
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_quot", quot, 16'h0);
        check("abort_rem", rem, 16'h0);
        check("abort_flags", {V, N, Z}, 3'b000);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        held_q = '0;
        seen   = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("abort_no_activity", seen, 0);

`ifdef DIV_SIGNED_EN
        run_op(16'hFFF9, 16'h0002, 1'b1, 0);
        idle_after_done();
        run_op(16'h8000, 16'hFFFF, 1'b1, 0);
        idle_after_done();
        run_op(16'h8000, 16'hFFFF, 1'b0, 0);
        idle_after_done();
`endif

        // Randomized operands, mixed gaps including back-to-back
        for (int t = 0; t < 40; t++) begin
            int sel, gap;
            sel = int'($urandom_range(0, 9));
            a   = W'($urandom);
            if (sel == 0)     b = '0;
            else if (sel < 4) b = W'($urandom_range(1, 15));
            else              b = W'($urandom);
            if (sel == 9) a = 16'h8000;
`ifdef DIV_SIGNED_EN
            s = bit'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run_op(a, b, s, (b != 0 && sel == 5) ? 2 : 0);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle_after_done();
            if (gap > 1) begin
                @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
